// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
package clk_rst_seq_pkg;

    localparam int STATE_W = 3;

    // Sequencer states; encodings are visible on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 3'd0,
        ST_STRETCH = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SWRST   = 3'd4
    } seq_state_e;

    // Bits needed to hold the values 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module clk_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift a constant 1 through the chain; any reset_n low clears it at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Reset sequencer: synchronise and stretch reset_n, then release FANOUT
// downstream resets one at a time, STAGGER cycles apart, bit 0 first.
//
// Software reset handshake (four-phase, level based):
//   req rises -> (in RUN) ack rises and all outputs reassert;
//   req falls -> ack falls and the stretch/release sequence runs again.
//   req is only acted on in RUN; in other states ack stays 0.
module clk_rst_sequencer
    import clk_rst_seq_pkg::*;
#(
    parameter int FANOUT      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sw_rst_req,
    output logic              sw_rst_ack,
    output logic [FANOUT-1:0] rst_n_out,
    output logic              rst_done,
    output logic [2:0]        state_o
);

    localparam int CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int IDX_W   = cnt_width(FANOUT);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FANOUT - 1);

    logic              w_rst_sync_n;

    seq_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [FANOUT-1:0] r_rst_n_out;
    logic              r_rst_done;
    logic              r_ack;

    seq_state_e        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [FANOUT-1:0] w_rst_n_out_nxt;
    logic              w_rst_done_nxt;
    logic              w_ack_nxt;

    clk_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .rst_sync_n (w_rst_sync_n)
    );

    // State, counters and registered outputs; reset_n clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n_out <= '0;
            r_rst_done  <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_n_out <= w_rst_n_out_nxt;
            r_rst_done  <= w_rst_done_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    // Next-state and next-output decode for the release sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_rst_n_out_nxt = r_rst_n_out;
        w_rst_done_nxt  = r_rst_done;
        w_ack_nxt       = r_ack;

        case (r_state)
            ST_HOLD: begin
                w_cnt_nxt       = '0;
                w_idx_nxt       = '0;
                w_rst_n_out_nxt = '0;
                w_rst_done_nxt  = 1'b0;
                w_ack_nxt       = 1'b0;
                if (w_rst_sync_n) begin
                    w_state_nxt = ST_STRETCH;
                end
            end

            ST_STRETCH: begin
                if (r_cnt == STRETCH_LAST) begin
                    // First output goes out on the same edge that leaves STRETCH.
                    w_state_nxt        = ST_RELEASE;
                    w_cnt_nxt          = '0;
                    w_idx_nxt          = '0;
                    w_rst_n_out_nxt[0] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_cnt_nxt      = '0;
                    w_rst_done_nxt = 1'b1;
                end else if (r_cnt == STAGGER_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    for (int i = 0; i < FANOUT; i++) begin
                        if (IDX_W'(i) == (r_idx + IDX_W'(1))) begin
                            w_rst_n_out_nxt[i] = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (sw_rst_req) begin
                    w_state_nxt     = ST_SWRST;
                    w_rst_n_out_nxt = '0;
                    w_rst_done_nxt  = 1'b0;
                    w_ack_nxt       = 1'b1;
                end
            end

            ST_SWRST: begin
                if (!sw_rst_req) begin
                    w_state_nxt = ST_STRETCH;
                    w_ack_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            default: begin
                // Unused encodings fall back to a full reset hold.
                w_state_nxt     = ST_HOLD;
                w_cnt_nxt       = '0;
                w_idx_nxt       = '0;
                w_rst_n_out_nxt = '0;
                w_rst_done_nxt  = 1'b0;
                w_ack_nxt       = 1'b0;
            end
        endcase
    end

    assign sw_rst_ack = r_ack;
    assign rst_n_out  = r_rst_n_out;
    assign rst_done   = r_rst_done;
    assign state_o    = r_state;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: two configurations share stimulus; each has a
// timeline model that pushes expected outputs and a monitor that pops them.
module tb_clk_rst_sequencer;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic sw_rst_req = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- per-configuration DUT, model, scoreboard ----------------
    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int F      = (g == 0) ? 4 : 1;
        localparam int SS     = 2;
        localparam int ST     = (g == 0) ? 16 : 1;
        localparam int SG     = (g == 0) ? 4 : 1;
        localparam int DONE_N = ST + (F - 1) * SG + 1;
        localparam int W      = F + 5;

        logic         sw_rst_ack;
        logic         rst_done;
        logic [F-1:0] rst_n_out;
        logic [2:0]   state_o;

        logic [W-1:0] exp_q[$];
        logic [W-1:0] got_w;
        logic [W-1:0] exp_w;

        // Model: mode 0 = held in reset, 1 = sequence running, 2 = sw reset.
        // m_e counts edges sampling reset_n high; m_n counts edges since the
        // edge that entered the stretch period.
        int m_mode = 0;
        int m_e    = 0;
        int m_n    = 0;

        clk_rst_sequencer #(
            .FANOUT      (F),
            .SYNC_STAGES (SS),
            .STRETCH     (ST),
            .STAGGER     (SG)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .sw_rst_req (sw_rst_req),
            .sw_rst_ack (sw_rst_ack),
            .rst_n_out  (rst_n_out),
            .rst_done   (rst_done),
            .state_o    (state_o)
        );

        function automatic logic [W-1:0] model_out(input int mode, input int n);
            logic [F-1:0] bits;
            logic [2:0]   st;
            logic         ack;
            logic         done;
            bits = '0;
            st   = 3'd0;
            ack  = 1'b0;
            done = 1'b0;
            if (mode == 2) begin
                st  = 3'd4;
                ack = 1'b1;
            end else if (mode == 1) begin
                for (int i = 0; i < F; i++) begin
                    if (n >= ST + i * SG) bits[i] = 1'b1;
                end
                done = (n >= DONE_N);
                if (n < ST)          st = 3'd1;
                else if (n < DONE_N) st = 3'd2;
                else                 st = 3'd3;
            end
            return {st, ack, done, bits};
        endfunction

        // Reference timeline: advance on each edge and queue the expected outputs.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                m_mode = 0;
                m_e    = 0;
                m_n    = 0;
            end else begin
                case (m_mode)
                    0: begin
                        m_e++;
                        if (m_e == SS + 1) begin
                            m_mode = 1;
                            m_n    = 0;
                        end
                    end
                    1: begin
                        if (m_n >= DONE_N && sw_rst_req) m_mode = 2;
                        else if (m_n < DONE_N)           m_n++;
                    end
                    default: begin
                        if (!sw_rst_req) begin
                            m_mode = 1;
                            m_n    = 0;
                        end
                    end
                endcase
            end
            exp_q.push_back(model_out(m_mode, m_n));
        end

        // Monitor: after each edge (clock or async reset) compare against the queue head.
        always @(posedge clk or negedge reset_n) begin
            #1;
            got_w = {state_o, sw_rst_ack, rst_done, rst_n_out};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cfg%0d outputs @%0t: got %h, no expected entry queued", g, $time, got_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    n_err++;
                    $display("FAIL cfg%0d outputs @%0t: got state=%0d ack=%b done=%b rst=%b, expected state=%0d ack=%b done=%b rst=%b",
                             g, $time, got_w[W-1 -: 3], got_w[F+1], got_w[F], got_w[F-1:0],
                             exp_w[W-1 -: 3], exp_w[F+1], exp_w[F], exp_w[F-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset_n between edges so the asynchronous clear is observed on its own.
    task automatic pulse_reset(input int low_cycles);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // reset_n high for exactly one sampled edge, then low again.
    task automatic glitch_reset();
        pulse_reset(1);
        @(negedge clk);
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Power-on: low for 10 cycles, then a full release sequence.
        step(10);
        reset_n = 1'b1;
        step(40);

        // Software reset handshake from RUN.
        sw_rst_req = 1'b1;
        step(3);
        sw_rst_req = 1'b0;
        step(40);

        // Mid-sequence reset while two outputs are released, then re-release.
        pulse_reset(2);
        step(24);
        pulse_reset(3);
        step(40);

        // Request raised during STRETCH and held into RUN.
        pulse_reset(3);
        step(8);
        sw_rst_req = 1'b1;
        step(40);
        sw_rst_req = 1'b0;
        step(40);

        // Short glitch on reset_n.
        glitch_reset();
        step(40);

        // Randomised mix of everything above.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    pulse_reset($urandom_range(1, 4));
                    step($urandom_range(0, 40));
                end
                1: begin
                    glitch_reset();
                    step($urandom_range(0, 10));
                end
                2: begin
                    sw_rst_req = 1'b1;
                    step($urandom_range(1, 30));
                end
                3: begin
                    sw_rst_req = 1'b0;
                    step($urandom_range(1, 60));
                end
                default: begin
                    sw_rst_req = 1'b1;
                    step(1);
                    sw_rst_req = 1'b0;
                    step($urandom_range(1, 5));
                end
            endcase
        end
        sw_rst_req = 1'b0;
        step(50);

        // Every queued expectation must have been consumed.
        n_vec++;
        if (g_cfg[0].exp_q.size() != 0) begin
            n_err++;
            $display("FAIL cfg0 drain: %0d entries left, expected 0", g_cfg[0].exp_q.size());
        end
        n_vec++;
        if (g_cfg[1].exp_q.size() != 0) begin
            n_err++;
            $display("FAIL cfg1 drain: %0d entries left, expected 0", g_cfg[1].exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
